// File: rtl/arp_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : arp_rx_filter
// Brief    : ARP request/reply detector with multi-IP match and result FIFO
// Revision : 1.0 - initial release
// ============================================================================
module arp_rx_filter #(
  parameter int NUM_IP       = 2,
  parameter int ACCEPT_REPLY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [47:0]           my_mac,
  input  logic [32*NUM_IP-1:0]  my_ip,
  input  logic [NUM_IP-1:0]     ip_en,
  input  logic                  data_valid,
  input  logic [7:0]            data_rx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_reply,
  output logic [2:0]            out_ip_idx,
  output logic [47:0]           out_mac,
  output logic [31:0]           out_ip,
  output logic [15:0]           rx_frames,
  output logic [7:0]            ovf_drops
);

  localparam int              c_AW   = $clog2(FIFO_DEPTH);
  localparam int              c_EW   = 84;
  localparam logic [c_AW:0]   c_FULL = FIFO_DEPTH[c_AW:0];
  // ethertype, htype, ptype, hlen, plen packed in wire order
  localparam logic [63:0]     c_HDR  = 64'h0806_0001_0800_06_04;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDR   = 2'd1,
    S_PAD   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_byte_cnt, w_cnt_nxt, w_off;
  logic        w_cap, w_eof;

  logic [47:0] r_dst, r_sha, r_tha;
  logic [79:0] r_ctl;
  logic [31:0] r_spa, r_tpa;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state    <= data_valid ? S_DRAIN : S_IDLE;
      r_byte_cnt <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_byte_cnt;
    w_off       = r_byte_cnt;
    w_cap       = 1'b0;
    w_eof       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_valid) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = 6'd1;
          w_off       = 6'd0;
          w_cap       = 1'b1;
        end
      end
      S_HDR: begin
        if (data_valid) begin
          w_cap     = 1'b1;
          w_cnt_nxt = r_byte_cnt + 6'd1;
          if (r_byte_cnt == 6'd41) w_state_nxt = S_PAD;
        end else begin
          w_eof       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PAD: begin
        if (data_valid) begin
          if (r_byte_cnt != 6'd63) w_cnt_nxt = r_byte_cnt + 6'd1;
        end else begin
          w_eof       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!data_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Each field shifts in MSB-first while the byte offset lies in its range
  always_ff @(posedge clk) begin
    if (areset) begin
      r_dst <= '0;
      r_ctl <= '0;
      r_sha <= '0;
      r_spa <= '0;
      r_tha <= '0;
      r_tpa <= '0;
    end else if (w_cap) begin
      if (w_off <= 6'd5)                     r_dst <= {r_dst[39:0], data_rx};
      if (w_off >= 6'd12 && w_off <= 6'd21)  r_ctl <= {r_ctl[71:0], data_rx};
      if (w_off >= 6'd22 && w_off <= 6'd27)  r_sha <= {r_sha[39:0], data_rx};
      if (w_off >= 6'd28 && w_off <= 6'd31)  r_spa <= {r_spa[23:0], data_rx};
      if (w_off >= 6'd32 && w_off <= 6'd37)  r_tha <= {r_tha[39:0], data_rx};
      if (w_off >= 6'd38 && w_off <= 6'd41)  r_tpa <= {r_tpa[23:0], data_rx};
    end
  end

  logic       w_hit_any;
  logic [2:0] w_hit_idx;
  logic       w_hdr_ok, w_is_req, w_is_rep, w_match;

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = 3'd0;
    for (int i = NUM_IP - 1; i >= 0; i--) begin
      if (ip_en[i] && (r_tpa == my_ip[32*i +: 32])) begin
        w_hit_any = 1'b1;
        w_hit_idx = 3'(i);
      end
    end
  end

  assign w_hdr_ok = (r_ctl[79:16] == c_HDR);
  assign w_is_req = (r_ctl[15:0] == 16'd1) && (r_dst == 48'hFFFF_FFFF_FFFF);
  assign w_is_rep = (ACCEPT_REPLY != 0) && (r_ctl[15:0] == 16'd2) &&
                    (r_dst == my_mac) && (r_tha == my_mac);
  assign w_match  = w_eof && (r_state == S_PAD) && w_hdr_ok && w_hit_any &&
                    (w_is_req || w_is_rep);

  logic [c_EW-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr, r_rptr;
  logic [c_AW:0]   r_count;
  logic [c_EW-1:0] r_last, w_head;
  logic            w_full, w_pop, w_push;

  assign out_valid = (r_count != '0);
  assign w_full    = (r_count == c_FULL);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = w_match && (!w_full || w_pop);
  assign w_head    = out_valid ? r_mem[r_rptr] : r_last;
  assign {out_is_reply, out_ip_idx, out_mac, out_ip} = w_head;

  always_ff @(posedge clk) begin
    if (w_push && !areset) r_mem[r_wptr] <= {w_is_rep, w_hit_idx, r_sha, r_spa};
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      rx_frames <= '0;
      ovf_drops <= '0;
    end else begin
      if (w_eof && rx_frames != 16'hFFFF) rx_frames <= rx_frames + 16'd1;
      if (w_match && w_full && !w_pop && ovf_drops != 8'hFF) ovf_drops <= ovf_drops + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arp_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_rx_filter
// Brief    : Scoreboard bench for arp_rx_filter (reply-enabled and request-only)
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_rx_filter;

  localparam logic [47:0] MY_MAC = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] IP0    = 32'hC0A8_0101;
  localparam logic [31:0] IP1    = 32'h0A00_0005;

  logic        clk = 1'b0;
  logic        areset, data_valid, out_ready;
  logic [7:0]  data_rx;
  logic [47:0] my_mac;
  logic [63:0] my_ip;
  logic [1:0]  ip_en;

  logic        a_valid, a_rep, b_valid, b_rep;
  logic [2:0]  a_idx, b_idx;
  logic [47:0] a_mac, b_mac;
  logic [31:0] a_ip, b_ip;
  logic [15:0] a_rx, b_rx;
  logic [7:0]  a_ovf, b_ovf;

  arp_rx_filter #(.NUM_IP(2), .ACCEPT_REPLY(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .areset(areset), .my_mac(my_mac), .my_ip(my_ip), .ip_en(ip_en),
    .data_valid(data_valid), .data_rx(data_rx), .out_valid(a_valid), .out_ready(out_ready),
    .out_is_reply(a_rep), .out_ip_idx(a_idx), .out_mac(a_mac), .out_ip(a_ip),
    .rx_frames(a_rx), .ovf_drops(a_ovf)
  );

  arp_rx_filter #(.NUM_IP(2), .ACCEPT_REPLY(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .areset(areset), .my_mac(my_mac), .my_ip(my_ip), .ip_en(ip_en),
    .data_valid(data_valid), .data_rx(data_rx), .out_valid(b_valid), .out_ready(out_ready),
    .out_is_reply(b_rep), .out_ip_idx(b_idx), .out_mac(b_mac), .out_ip(b_ip),
    .rx_frames(b_rx), .ovf_drops(b_ovf)
  );

  always #5 clk = ~clk;

  logic [83:0] q_a[$];
  logic [83:0] q_b[$];
  logic [83:0] e_a, e_b;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rx_exp = 0;
  logic [7:0]  fr [64];

  // Monitor: pops and compares whenever a head is handed over
  always @(negedge clk) begin
    if (a_valid && out_ready) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_a: got %h, required no entry", {a_rep, a_idx, a_mac, a_ip});
      end else begin
        e_a = q_a.pop_front();
        if ({a_rep, a_idx, a_mac, a_ip} !== e_a) begin
          n_fail++;
          $display("FAIL entry_a: got %h required %h", {a_rep, a_idx, a_mac, a_ip}, e_a);
        end
      end
    end
    if (b_valid && out_ready) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_b: got %h, required no entry", {b_rep, b_idx, b_mac, b_ip});
      end else begin
        e_b = q_b.pop_front();
        if ({b_rep, b_idx, b_mac, b_ip} !== e_b) begin
          n_fail++;
          $display("FAIL entry_b: got %h required %h", {b_rep, b_idx, b_mac, b_ip}, e_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    data_valid = v;
    data_rx    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] op, input logic [47:0] sha,
                       input logic [31:0] spa, input logic [47:0] tha, input logic [31:0] tpa);
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      fr[k]      = dst[47-8*k -: 8];
      fr[6+k]    = 8'h60 + 8'(k);
      fr[22+k]   = sha[47-8*k -: 8];
      fr[32+k]   = tha[47-8*k -: 8];
    end
    for (int k = 0; k < 4; k++) begin
      fr[28+k] = spa[31-8*k -: 8];
      fr[38+k] = tpa[31-8*k -: 8];
    end
    fr[12] = 8'h08; fr[13] = 8'h06; fr[14] = 8'h00; fr[15] = 8'h01;
    fr[16] = 8'h08; fr[17] = 8'h00; fr[18] = 8'h06; fr[19] = 8'h04;
    fr[20] = op[15:8]; fr[21] = op[7:0];
  endtask

  task automatic send_bytes(input int len);
    for (int i = 0; i < len; i++) drive(1'b1, fr[i]);
  endtask

  task automatic send(input int len);
    send_bytes(len);
    drive(1'b0, 8'h00);
    rx_exp++;
  endtask

  task automatic expect_push(input logic rep, input logic [2:0] idx,
                             input logic [47:0] sha, input logic [31:0] spa);
    q_a.push_back({rep, idx, sha, spa});
    if (!rep) q_b.push_back({rep, idx, sha, spa});
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || a_valid || b_valid) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (k >= 50) begin
      n_fail++;
      $display("FAIL %s: drain timeout, pending a=%0d b=%0d required 0", name, q_a.size(), q_b.size());
    end
  endtask

  initial begin
    areset = 1'b1; data_valid = 1'b0; data_rx = 8'h00; out_ready = 1'b0;
    my_mac = MY_MAC; my_ip = {IP1, IP0}; ip_en = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_a", a_valid, 0);
    check("rst_valid_b", b_valid, 0);
    check("rst_head_a", {a_rep, a_idx, a_mac}, 0);
    check("rst_ip_a", a_ip, 0);
    check("rst_rx_a", a_rx, 0);
    check("rst_ovf_a", a_ovf, 0);
    areset = 1'b0;

    // Broadcast request hitting entry 1, latency checked around the gap edge
    build(BCAST, 16'd1, 48'hAABB_CCDD_EE01, 32'h0A00_0009, 48'h0, IP1);
    expect_push(1'b0, 3'd1, 48'hAABB_CCDD_EE01, 32'h0A00_0009);
    send_bytes(42);
    check("t1_valid_before_eof", a_valid, 0);
    drive(1'b0, 8'h00);
    rx_exp++;
    check("t1_latency_a", a_valid, 1);
    check("t1_latency_b", b_valid, 1);
    out_ready = 1'b1;
    wait_drain("t1_drain");

    ip_en = 2'b01;
    send(42);
    wait_drain("t2_disabled");
    check("t2_rx_a", a_rx, 64'(rx_exp));
    ip_en = 2'b11;

    // Both entries hold the same address: lowest index wins
    my_ip = {IP1, IP1};
    build(BCAST, 16'd1, 48'hAABB_CCDD_EE02, 32'h0A00_000A, 48'h0, IP1);
    expect_push(1'b0, 3'd0, 48'hAABB_CCDD_EE02, 32'h0A00_000A);
    send(42);
    wait_drain("t2b_priority");
    my_ip = {IP1, IP0};

    build(MY_MAC, 16'd2, 48'hAABB_CCDD_EE03, 32'hC0A8_0107, MY_MAC, IP0);
    expect_push(1'b1, 3'd0, 48'hAABB_CCDD_EE03, 32'hC0A8_0107);
    send(42);
    wait_drain("t3_reply");

    build(MY_MAC, 16'd2, 48'hAABB_CCDD_EE04, 32'hC0A8_0108, 48'h02_11_22_33_44_56, IP0);
    send(42);
    wait_drain("t3b_bad_tha");

    build(BCAST, 16'd1, 48'hAABB_CCDD_EE05, 32'hC0A8_0109, 48'h0, IP0);
    send(41);
    wait_drain("t4_short");
    expect_push(1'b0, 3'd0, 48'hAABB_CCDD_EE05, 32'hC0A8_0109);
    send(60);
    wait_drain("t4_padded");

    // Six back-to-back matches into a 4-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      build(BCAST, 16'd1, {40'hAABB_CCDD_50, 8'(f)}, 32'h0A00_0100 + 32'(f), 48'h0, IP1);
      if (f < 4) expect_push(1'b0, 3'd1, {40'hAABB_CCDD_50, 8'(f)}, 32'h0A00_0100 + 32'(f));
      send(42);
    end
    check("t5_ovf_a", a_ovf, 2);
    check("t5_ovf_b", b_ovf, 2);
    check("t5_full_valid", a_valid, 1);
    out_ready = 1'b1;
    wait_drain("t5_drain");
    check("t5_rx_a", a_rx, 64'(rx_exp));
    check("t5_rx_b", b_rx, 64'(rx_exp));

    // Reset lands on byte 20 of a valid request
    build(BCAST, 16'd1, 48'hAABB_CCDD_EE06, 32'h0A00_0011, 48'h0, IP1);
    for (int i = 0; i < 42; i++) begin
      areset = (i == 20);
      drive(1'b1, fr[i]);
    end
    areset = 1'b0;
    drive(1'b0, 8'h00);
    rx_exp = 0;
    check("t6_rx_after_rst", a_rx, 0);
    check("t6_ovf_after_rst", a_ovf, 0);
    check("t6_no_push", a_valid, 0);
    build(BCAST, 16'd1, 48'hAABB_CCDD_EE07, 32'h0A00_0012, 48'h0, IP1);
    expect_push(1'b0, 3'd1, 48'hAABB_CCDD_EE07, 32'h0A00_0012);
    send(42);
    wait_drain("t6_after_rst");
    check("t6_rx_a", a_rx, 64'(rx_exp));
    check("t6_rx_b", b_rx, 64'(rx_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
